backlight_level_ctrl: RTL and testbench

// - Upstream stage of the backlight PWM generator.
// - Turns the raw brightness push-button (GMUX_PL6A, active-low) into a registered brightness level 1..16 plus a one-cycle update strobe.
// - Synchronises and debounces the button. A short press steps the level up, wrapping. Holding the button auto-repeats, saturating at max.
// - The PWM stage consumes BKLT_LEVEL directly as its duty-cycle index.

---
 rtl/backlight_level_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_backlight_level_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/backlight_level_ctrl.sv
// Backlight brightness level control.
// Synchronises and debounces the active-low brightness button, then steps a
// 1..16 level on each short press (wrapping) and auto-repeats while the
// button is held (saturating). Level and update strobe are registered together.
module backlight_level_ctrl #(
    parameter int DEBOUNCE_CYC   = 330000,
    parameter int REPEAT_DLY_CYC = 16500000,
    parameter int REPEAT_CYC     = 6600000,
    parameter int LEVEL_MIN      = 1,
    parameter int LEVEL_MAX      = 16,
    parameter int LEVEL_RST      = 10
) (
    input  logic       LPC_CLK33M_GMUX,
    input  logic       GMUX_RST_L,
    input  logic       GMUX_PL6A,
    input  logic       LVDS_IG_BKL_ON,
    output logic [4:0] BKLT_LEVEL,
    output logic       LEVEL_STROBE,
    output logic       BTN_DEB_L
);

    localparam int RPT_MAX = (REPEAT_DLY_CYC > REPEAT_CYC) ? REPEAT_DLY_CYC : REPEAT_CYC;
    localparam int DEB_W   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TMR_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DLY_CYC - 1);
    localparam logic [TMR_W-1:0] RPT_LAST = TMR_W'(REPEAT_CYC - 1);
    localparam logic [4:0]       LVL_MIN  = 5'(LEVEL_MIN);
    localparam logic [4:0]       LVL_MAX  = 5'(LEVEL_MAX);
    localparam logic [4:0]       LVL_RST  = 5'(LEVEL_RST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_e;

    logic [1:0]       rst_sync_q;
    logic             rst_int_n_s;
    logic [1:0]       btn_sync_q;
    logic [1:0]       bkl_sync_q;
    logic             sync_btn_s;
    logic             sync_bkl_s;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             btn_deb_q, btn_deb_d;
    logic             btn_deb_prev_q;
    logic             press_s;
    logic             release_s;
    state_e           state_q, state_d;
    logic [TMR_W-1:0] rpt_tmr_q, rpt_tmr_d;
    logic             step_short_s;
    logic             step_rpt_s;
    logic [4:0]       level_q, level_d;
    logic             strobe_q, strobe_d;

    // Reset: asserts asynchronously, releases synchronously to the clock.
    always_ff @(posedge LPC_CLK33M_GMUX or negedge GMUX_RST_L) begin
        if (!GMUX_RST_L) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_q[1];

    // Two-flop synchronisers for the asynchronous button and backlight-on inputs.
    always_ff @(posedge LPC_CLK33M_GMUX or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            btn_sync_q <= 2'b11;
            bkl_sync_q <= 2'b00;
        end else begin
            btn_sync_q <= {btn_sync_q[0], GMUX_PL6A};
            bkl_sync_q <= {bkl_sync_q[0], LVDS_IG_BKL_ON};
        end
    end

    assign sync_btn_s = btn_sync_q[1];
    assign sync_bkl_s = bkl_sync_q[1];

    // Debounce: flip the debounced state only after a sustained mismatch.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        btn_deb_d = btn_deb_q;
        if (sync_btn_s == btn_deb_q) begin
            deb_cnt_d = {DEB_W{1'b0}};
        end else if (deb_cnt_q == DEB_LAST) begin
            btn_deb_d = sync_btn_s;
            deb_cnt_d = {DEB_W{1'b0}};
        end else begin
            deb_cnt_d = deb_cnt_q + {{(DEB_W-1){1'b0}}, 1'b1};
        end
    end

    // Debounce state registers plus a delayed copy for press-edge detection.
    always_ff @(posedge LPC_CLK33M_GMUX or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            deb_cnt_q      <= {DEB_W{1'b0}};
            btn_deb_q      <= 1'b1;
            btn_deb_prev_q <= 1'b1;
        end else begin
            deb_cnt_q      <= deb_cnt_d;
            btn_deb_q      <= btn_deb_d;
            btn_deb_prev_q <= btn_deb_q;
        end
    end

    assign press_s   = btn_deb_prev_q & ~btn_deb_q;
    assign release_s = btn_deb_q;

    // Press/hold/repeat FSM; backlight off forces IDLE without stepping.
    always_comb begin
        state_d      = state_q;
        rpt_tmr_d    = rpt_tmr_q;
        step_short_s = 1'b0;
        step_rpt_s   = 1'b0;
        if (!sync_bkl_s) begin
            state_d   = IDLE;
            rpt_tmr_d = {TMR_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_s) begin
                        step_short_s = 1'b1;
                        state_d      = HOLD;
                        rpt_tmr_d    = {TMR_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (release_s) begin
                        state_d   = IDLE;
                        rpt_tmr_d = {TMR_W{1'b0}};
                    end else if (rpt_tmr_q == DLY_LAST) begin
                        step_rpt_s = 1'b1;
                        state_d    = RPT;
                        rpt_tmr_d  = {TMR_W{1'b0}};
                    end else begin
                        rpt_tmr_d = rpt_tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                RPT: begin
                    if (release_s) begin
                        state_d   = IDLE;
                        rpt_tmr_d = {TMR_W{1'b0}};
                    end else if (rpt_tmr_q == RPT_LAST) begin
                        step_rpt_s = 1'b1;
                        rpt_tmr_d  = {TMR_W{1'b0}};
                    end else begin
                        rpt_tmr_d = rpt_tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_tmr_d = {TMR_W{1'b0}};
                end
            endcase
        end
    end

    // Next level: short press wraps at max, auto-repeat saturates at max.
    always_comb begin
        level_d  = level_q;
        strobe_d = 1'b0;
        if (step_short_s) begin
            level_d  = (level_q == LVL_MAX) ? LVL_MIN : (level_q + 5'd1);
            strobe_d = 1'b1;
        end else if (step_rpt_s) begin
            if (level_q < LVL_MAX) begin
                level_d  = level_q + 5'd1;
                strobe_d = 1'b1;
            end else begin
                level_d  = level_q;
            end
        end else begin
            level_d = level_q;
        end
    end

    // FSM, repeat timer, level and strobe registers.
    always_ff @(posedge LPC_CLK33M_GMUX or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_q   <= IDLE;
            rpt_tmr_q <= {TMR_W{1'b0}};
            level_q   <= LVL_RST;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_tmr_q <= rpt_tmr_d;
            level_q   <= level_d;
            strobe_q  <= strobe_d;
        end
    end

    assign BKLT_LEVEL   = level_q;
    assign LEVEL_STROBE = strobe_q;
    assign BTN_DEB_L    = btn_deb_q;

endmodule

// File: tb/tb_backlight_level_ctrl.sv
// Directed testbench for backlight_level_ctrl with shortened timing parameters.
module tb_backlight_level_ctrl;

    logic       clk;
    logic       rst_n;
    logic       pl6a;
    logic       bkl_on;
    logic [4:0] level;
    logic       strobe;
    logic       deb_l;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int dbl_strobe_cnt = 0;
    int deb_low_cnt = 0;
    logic strobe_prev = 1'b0;
    int s0;

    backlight_level_ctrl #(
        .DEBOUNCE_CYC   (4),
        .REPEAT_DLY_CYC (20),
        .REPEAT_CYC     (8),
        .LEVEL_MIN      (1),
        .LEVEL_MAX      (16),
        .LEVEL_RST      (10)
    ) dut (
        .LPC_CLK33M_GMUX (clk),
        .GMUX_RST_L      (rst_n),
        .GMUX_PL6A       (pl6a),
        .LVDS_IG_BKL_ON  (bkl_on),
        .BKLT_LEVEL      (level),
        .LEVEL_STROBE    (strobe),
        .BTN_DEB_L       (deb_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe strobes and debounced state once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (strobe === 1'b1 && strobe_prev === 1'b1) dbl_strobe_cnt <= dbl_strobe_cnt + 1;
        if (deb_l === 1'b0) deb_low_cnt <= deb_low_cnt + 1;
        strobe_prev <= strobe;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press for n cycles, release, then wait for the release to debounce.
    task automatic press(input int n);
        @(posedge clk); #1 pl6a = 1'b0;
        repeat (n) @(posedge clk);
        #1 pl6a = 1'b1;
        repeat (30) @(posedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        pl6a   = 1'b1;
        bkl_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_level", 32'(level), 32'd10);
        check_val("rst_strobe", 32'(strobe), 32'd0);
        check_val("rst_deb", 32'(deb_l), 32'd1);
        @(negedge clk) rst_n = 1'b1;

        // 1. idle after reset
        repeat (50) @(posedge clk);
        #1;
        check_val("idle_level", 32'(level), 32'd10);
        check_val("idle_strobes", 32'(strobe_cnt), 32'd0);
        check_val("idle_deb", 32'(deb_l), 32'd1);

        // 2. glitch shorter than debounce
        @(posedge clk); #1 pl6a = 1'b0;
        repeat (3) @(posedge clk);
        #1 pl6a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_val("glitch_deb_low", 32'(deb_low_cnt), 32'd0);
        check_val("glitch_level", 32'(level), 32'd10);
        check_val("glitch_strobes", 32'(strobe_cnt), 32'd0);

        // 3. short press, exact latency of 7 cycles
        s0 = strobe_cnt;
        @(posedge clk); #1 pl6a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 6) check_val("lat_before", 32'(level), 32'd10);
            if (i == 7) begin
                check_val("lat_level", 32'(level), 32'd11);
                check_val("lat_strobe", 32'(strobe), 32'd1);
            end
        end
        pl6a = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_val("short_level", 32'(level), 32'd11);
        check_val("short_strobes", 32'(strobe_cnt - s0), 32'd1);

        // 4. wrap from 16 to 1
        for (int k = 0; k < 5; k++) press(10);
        #1;
        check_val("reach_16", 32'(level), 32'd16);
        s0 = strobe_cnt;
        press(10);
        #1;
        check_val("wrap_level", 32'(level), 32'd1);
        check_val("wrap_strobes", 32'(strobe_cnt - s0), 32'd1);

        // 5. hold at 14: step at press, repeat after 20, then saturate
        for (int k = 0; k < 13; k++) press(10);
        #1;
        check_val("reach_14", 32'(level), 32'd14);
        s0 = strobe_cnt;
        @(posedge clk); #1 pl6a = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (i == 7)  check_val("hold_press", 32'(level), 32'd15);
            if (i == 26) check_val("hold_before_rpt", 32'(level), 32'd15);
            if (i == 27) check_val("hold_rpt", 32'(level), 32'd16);
        end
        check_val("hold_sat_level", 32'(level), 32'd16);
        check_val("hold_strobes", 32'(strobe_cnt - s0), 32'd2);
        pl6a = 1'b1;
        repeat (30) @(posedge clk);

        // 6a. backlight off: presses ignored
        bkl_on = 1'b0;
        repeat (5) @(posedge clk);
        s0 = strobe_cnt;
        press(10);
        #1;
        check_val("bkloff_level", 32'(level), 32'd16);
        check_val("bkloff_strobes", 32'(strobe_cnt - s0), 32'd0);

        // 6b. press in progress when backlight turns on is ignored
        @(posedge clk); #1 pl6a = 1'b0;
        repeat (10) @(posedge clk);
        #1 bkl_on = 1'b1;
        repeat (10) @(posedge clk);
        #1 pl6a = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_val("bklrise_level", 32'(level), 32'd16);
        check_val("bklrise_strobes", 32'(strobe_cnt - s0), 32'd0);

        // 6c. reach 11, press-and-hold to 12, reset mid-hold
        for (int k = 0; k < 11; k++) press(10);
        #1;
        check_val("reach_11", 32'(level), 32'd11);
        @(posedge clk); #1 pl6a = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_val("hold_12", 32'(level), 32'd12);
        rst_n = 1'b0;
        #2;
        check_val("async_rst_level", 32'(level), 32'd10);
        check_val("async_rst_deb", 32'(deb_l), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("post_rst_hold", 32'(level), 32'd10);
        repeat (10) @(posedge clk);
        #1;
        check_val("post_rst_press", 32'(level), 32'd11);
        pl6a = 1'b1;
        repeat (30) @(posedge clk);

        #1;
        check_val("no_dbl_strobe", 32'(dbl_strobe_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
